aes_128_decrypt_iter: RTL

AES_128_DECRYPT_ITER -- requirements
Module: aes_128_decrypt_iter

---
 rtl/aes_128_decrypt_iter_if.sv | 22 ++
 rtl/aes_128_decrypt_iter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_decrypt_iter_if.sv
// Handshake/data bundle between a ciphertext/key producer and the iterative AES-128 decryptor.
// master: drives in_valid/state/key/out_ready, receives in_ready/out_valid/out.
// slave : the decryptor side of the same signals.
interface aes_128_decrypt_iter_if;
    logic         in_valid;   // ciphertext/key pair offered
    logic         in_ready;   // decryptor idle and accepting
    logic [127:0] state;      // ciphertext, byte 0 in [127:120]
    logic [127:0] key;        // cipher key, same byte order
    logic         out_valid;  // plaintext available
    logic         out_ready;  // consumer takes plaintext
    logic [127:0] out;        // plaintext

    modport master (
        output in_valid, state, key, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, state, key, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/aes_128_decrypt_iter.sv
// Iterative AES-128 decryptor: forward key expansion to k10, then nine inverse rounds and a final round.
// Latency: out_valid rises 20 edges after acceptance (10 edges on a key-cache hit when enabled).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no new input meanwhile.
// Ports: clk, rst (async active-high), bus (slave modport of aes_128_decrypt_iter_if).
// Option: define AES_DEC_KEY_CACHE_EN to remember the last key and its k10, skipping expansion on a repeat key.
module aes_128_decrypt_iter (
    input  logic                         clk,
    input  logic                         rst,
    aes_128_decrypt_iter_if.slave        bus
);
    typedef enum logic [2:0] {IDLE, KEXP, ROUND, FINAL, DONE} fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   rc_q, rc_d;
    logic [127:0] s_q, s_d;
    logic [127:0] k_q, k_d;
    logic [127:0] out_q, out_d;
    logic         out_valid_q, out_valid_d;

    // GF(2^8) arithmetic with the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 = multiplicative inverse (0 maps to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // S-boxes are built from inversion plus the affine map rather than 256-entry tables.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] o;
        b = gf_inv(x);
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            o[i] = b[i] ^ b[3'(i + 4)] ^ b[3'(i + 5)] ^ b[3'(i + 6)] ^ b[3'(i + 7)] ^ c[i];
        return o;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] a;
        logic [7:0] d;
        d = 8'h05;
        for (int i = 0; i < 8; i++)
            a[i] = y[3'(i + 2)] ^ y[3'(i + 5)] ^ y[3'(i + 7)] ^ d[i];
        return gf_inv(a);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0: return 8'h01;
            4'd1: return 8'h02;
            4'd2: return 8'h04;
            4'd3: return 8'h08;
            4'd4: return 8'h10;
            4'd5: return 8'h20;
            4'd6: return 8'h40;
            4'd7: return 8'h80;
            4'd8: return 8'h1b;
            4'd9: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rk);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rk, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0]  ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Undo one expansion step: recover words 3..1 first, then word 0 needs the recovered word 3.
    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rk);
        logic [31:0] n0, n1, n2, n3;
        n3 = k[31:0]  ^ k[63:32];
        n2 = k[63:32] ^ k[95:64];
        n1 = k[95:64] ^ k[127:96];
        n0 = k[127:96] ^ sub_word({n3[23:0], n3[31:24]}) ^ {rk, 24'h0};
        return {n0, n1, n2, n3};
    endfunction

    // Byte b sits at row b%4, column b/4; row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int b = 0; b < 16; b++)
            o[127 - 8 * b -: 8] = inv_sbox(s[127 - 8 * b -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // rc indexes rcon in both directions: during KEXP it is the round being produced minus one,
    // during ROUND/FINAL k holds round rc+1 so the inverse step needs rcon[rc] as well.
    logic [127:0] k_fwd;
    logic [127:0] k_inv;
    logic [127:0] isb;
    assign k_fwd = key_fwd(k_q, rcon(rc_q));
    assign k_inv = key_inv(k_q, rcon(rc_q));
    assign isb   = inv_sub_bytes(inv_shift_rows(s_q));

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] ck_key_q, ck_key_d;
    logic [127:0] ck_k10_q, ck_k10_d;
    logic         ck_vld_q, ck_vld_d;
    logic         ck_hit;
    assign ck_hit = ck_vld_q && (bus.key == ck_key_q);
`endif

    always_comb begin
        fsm_d       = fsm_q;
        rc_d        = rc_q;
        s_d         = s_q;
        k_d         = k_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
`ifdef AES_DEC_KEY_CACHE_EN
        ck_key_d    = ck_key_q;
        ck_k10_d    = ck_k10_q;
        ck_vld_d    = ck_vld_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (bus.in_valid) begin
`ifdef AES_DEC_KEY_CACHE_EN
                    if (ck_hit) begin
                        k_d   = ck_k10_q;
                        s_d   = bus.state ^ ck_k10_q;
                        rc_d  = 4'd9;
                        fsm_d = ROUND;
                    end else begin
                        // Key is captured now; the entry becomes valid once k10 is known.
                        ck_key_d = bus.key;
                        ck_vld_d = 1'b0;
                        s_d      = bus.state;
                        k_d      = bus.key;
                        rc_d     = 4'd0;
                        fsm_d    = KEXP;
                    end
`else
                    s_d   = bus.state;
                    k_d   = bus.key;
                    rc_d  = 4'd0;
                    fsm_d = KEXP;
`endif
                end
            end
            KEXP: begin
                k_d  = k_fwd;
                rc_d = rc_q + 4'd1;
                if (rc_q == 4'd9) begin
                    // k_fwd is k10 here: apply the initial AddRoundKey on the same edge.
                    s_d   = s_q ^ k_fwd;
                    rc_d  = 4'd9;
                    fsm_d = ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
                    ck_k10_d = k_fwd;
                    ck_vld_d = 1'b1;
`endif
                end
            end
            ROUND: begin
                s_d  = inv_mix_columns(isb ^ k_inv);
                k_d  = k_inv;
                rc_d = rc_q - 4'd1;
                if (rc_q == 4'd1) fsm_d = FINAL;
            end
            FINAL: begin
                out_d       = isb ^ k_inv;
                out_valid_d = 1'b1;
                fsm_d       = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            rc_q        <= 4'd0;
            s_q         <= 128'h0;
            k_q         <= 128'h0;
            out_q       <= 128'h0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            rc_q        <= rc_d;
            s_q         <= s_d;
            k_q         <= k_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef AES_DEC_KEY_CACHE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ck_key_q <= 128'h0;
            ck_k10_q <= 128'h0;
            ck_vld_q <= 1'b0;
        end else begin
            ck_key_q <= ck_key_d;
            ck_k10_q <= ck_k10_d;
            ck_vld_q <= ck_vld_d;
        end
    end
`endif

    assign bus.in_ready  = (fsm_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
endmodule
